controlador_alvo: RTL



---
 rtl/equilibrio_pkg.sv | 26 ++
 rtl/controlador_alvo_contador_semente.sv | 36 +++
 rtl/controlador_alvo.sv | 110 +++++++++++
 3 files changed

// File: rtl/equilibrio_pkg.sv
// Shared types and constants for the balance-target sequencer and its checkers.
package equilibrio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SORTEIO,
        PULSO,
        ESPERA,
        PRONTO
    } estado_t;

    localparam int unsigned NUM_POS = 11;
    localparam int unsigned SEED_W  = 4;

    function automatic logic [NUM_POS-1:0] indice_para_onehot(input logic [SEED_W-1:0] idx);
        logic [NUM_POS-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_POS; i++) begin
            if (idx == SEED_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/controlador_alvo_contador_semente.sv
// Free-running mod-NUM_POS entropy counter with the no-repeat adjustment of the draw value.
module contador_semente
    import equilibrio_pkg::*;
#(
    parameter int unsigned NUM_POS = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ajustar,
    input  logic [3:0] indice,
    output logic [3:0] valor
);

    localparam logic [SEED_W-1:0] ULTIMO = SEED_W'(NUM_POS - 1);

    logic [SEED_W-1:0] cont;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont <= '0;
        end else if (cont == ULTIMO) begin
            cont <= '0;
        end else begin
            cont <= cont + SEED_W'(1);
        end
    end

    // Bump past the current target so consecutive draws always differ.
    always_comb begin
        valor = cont;
        if (ajustar && (cont == indice)) begin
            valor = (cont == ULTIMO) ? '0 : cont + SEED_W'(1);
        end
    end

endmodule

// File: rtl/controlador_alvo.sv
// Target sequencer: schedules draws (request or round timer), strobes the generator
// and reports each new target to the game logic through a valid/ack handshake.
module controlador_alvo
    import equilibrio_pkg::*;
#(
    parameter int unsigned NUM_POS     = 11,
    parameter int unsigned ROUND_TICKS = 50_000_000,
    parameter int unsigned TIMER_W     = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic       pedido,
    input  logic       ack,
    output logic [3:0] seed,
    output logic       gerar,
    output logic [3:0] indice,
    output logic       novo_valido,
    output logic [7:0] rodada,
    output logic       estouro
);

    localparam logic [TIMER_W-1:0] TIMER_CARGA = TIMER_W'(ROUND_TICKS - 1);

    estado_t              state;
    estado_t              state_d;
    logic                 gerar_d;
    logic [TIMER_W-1:0]   timer;
    logic [SEED_W-1:0]    valor;

    contador_semente #(
        .NUM_POS (NUM_POS)
    ) u_contador_semente (
        .clk     (clk),
        .rst_n   (rst_n),
        .ajustar (rodada != '0),
        .indice  (indice),
        .valor   (valor)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gerar <= 1'b0;
        end else begin
            state <= state_d;
            gerar <= gerar_d;
        end
    end

    always_comb begin
        state_d = state;
        if (!iniciar) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    state_d = SORTEIO;
                SORTEIO: state_d = PULSO;
                PULSO:   state_d = ESPERA;
                ESPERA:  state_d = PRONTO;
                PRONTO:  if (pedido || (timer == '0)) state_d = SORTEIO;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobe is registered from the next state so it is high exactly while in PULSO.
    always_comb begin
        gerar_d = (state_d == PULSO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed        <= '0;
            indice      <= '0;
            novo_valido <= 1'b0;
            rodada      <= '0;
            estouro     <= 1'b0;
            timer       <= '0;
        end else if (!iniciar) begin
            novo_valido <= 1'b0;
            rodada      <= '0;
            estouro     <= 1'b0;
        end else begin
            case (state)
                SORTEIO: begin
                    seed        <= valor;
                    indice      <= valor;
                    rodada      <= rodada + 8'd1;
                    novo_valido <= 1'b0;
                    if (novo_valido) begin
                        estouro <= 1'b1;
                    end
                end
                ESPERA: begin
                    novo_valido <= 1'b1;
                    timer       <= TIMER_CARGA;
                end
                PRONTO: begin
                    timer <= timer - TIMER_W'(1);
                    if (ack) begin
                        novo_valido <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
